controlador_interrupcao: RTL and testbench
==========================================

Name: controlador_interrupcao

Overview:
- Sequences interrupt entry and return for the core.
- Latches external interrupt requests, picks one by fixed priority at an instruction boundary, and captures the return PC.
- Drives the PC-source controls (desvia_interrup, retorna_pc) and the PC/interrupt-selection mux selects (save_pc, get_pc_interrup, get_interruption).
- Supplies pc_interrup and qual_interrupcao to that mux. No nesting.

Parameters:
DATA_WIDTH, 32, datapath word width
ADDR_WIDTH, 13, instruction address width
NUM_IRQ, 4, number of request lines (1..15)
VETOR_INTERRUP, 13'h0010, handler entry address (ADDR_WIDTH bits)

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
irq  input  NUM_IRQ  request lines, rising-edge sensitive, synchronous to clock
habilita_interrup  input  1  global enable (from control register)
fim_instrucao  input  1  pulse: current instruction retires this cycle (boundary)
valor_pc  input  ADDR_WIDTH  address of next instruction to execute
reti  input  1  pulse: return-from-interrupt instruction decoded
op_save_pc, op_get_pc, op_get_irq  input  1 each  decoded software requests to read PC / return PC / interrupt ID
pc_interrup  output  ADDR_WIDTH  saved return address
qual_interrupcao  output  DATA_WIDTH  serviced ID, zero-extended; 0 = none
desvia_interrup  output  1  one-cycle pulse: PC loads endereco_vetor
endereco_vetor  output  ADDR_WIDTH  constant VETOR_INTERRUP
retorna_pc  output  1  one-cycle pulse: PC loads pc_interrup
save_pc, get_pc_interrup, get_interruption  output  1 each  mux selects, mutually exclusive
pendentes  output  NUM_IRQ  pending bits
em_servico  output  1  high from SALVA through RETORNA inclusive

Behaviour:
- Reset (async, immediate): all outputs 0 except endereco_vetor; pendentes=0; irq_ant=0; state OCIOSO. Reset mid-service abandons the handler; no return is generated.
- Edge capture: irq_ant registers irq; pending[i] set when irq[i] & ~irq_ant[i]. Captured in all states, including while em_servico.
- Priority: lowest index wins; ID = index+1 (4-bit, zero-extended to DATA_WIDTH).
- FSM, one state per cycle unless noted:
  - OCIOSO: if habilita_interrup & fim_instrucao & |pendentes -> SALVA. Otherwise stay.
  - SALVA: pc_interrup<=valor_pc; qual_interrupcao<=ID; clear winning pending bit -> DESVIA.
  - DESVIA: desvia_interrup=1 for exactly this cycle -> EM_SERVICO.
  - EM_SERVICO: wait for reti -> RETORNA. fim_instrucao and new pending are ignored (no nesting).
  - RETORNA: retorna_pc=1 for exactly this cycle; qual_interrupcao<=0 -> OCIOSO.
  - A pending request may be taken again at the next boundary after RETORNA.
- Latency:
  - Boundary cycle T with pending -> desvia_interrup at T+2.
  - reti at T -> retorna_pc at T+1.
- Pending-bit conflict: set and clear of the same bit in the same cycle -> set wins (the new edge is not lost).
- habilita_interrup low: pending bits keep accumulating; no entry. Deassertion during EM_SERVICO does not affect return.
- reti outside EM_SERVICO is ignored.
- Mux selects are combinational from the op_* inputs, with priority op_save_pc > op_get_pc > op_get_irq; at most one output is high.
- pc_interrup and qual_interrupcao hold their values until the next SALVA (or RETORNA for qual_interrupcao).

Decomposition:
- Shared package: FSM state encoding (3-bit: OCIOSO, SALVA, DESVIA, EM_SERVICO, RETORNA) and the ID width constant (4).
- Sub-module: detector_borda_irq (per-line edge detect plus pending register with set-over-clear). Priority encoder and FSM stay in the top.

Test Plan:
1. Reset with irq=4'b0000; pulse irq[2] and hold it high; assert fim_instrucao with valor_pc=13'h0123, habilita_interrup=1 -> desvia_interrup 2 cycles later; pc_interrup=13'h0123; qual_interrupcao=3; pendentes=0.
2. Rising edges on irq[1] and irq[3] in the same cycle, then a boundary -> ID=2 serviced; pendentes=4'b1000 remains. After reti -> retorna_pc next cycle; at the next boundary ID=4 is serviced.
3. Pulse irq[0] during EM_SERVICO -> pendentes[0]=1 and no desvia_interrup. After reti and RETORNA, the next boundary takes ID=1.
4. habilita_interrup=0 with irq[1] edge and 5 boundaries -> no desvia_interrup; pendentes=4'b0010. Set enable=1 -> entry at the next boundary.
5. New irq edge on the same cycle as SALVA clears that bit -> bit remains 1. reti pulsed in OCIOSO -> retorna_pc stays 0.
6. op_save_pc=op_get_irq=1 -> only save_pc=1. Assert reset_n=0 during EM_SERVICO -> em_servico, pc_interrup, qual_interrupcao and pendentes are 0 immediately, with no clock edge.

Source files
------------

// File: rtl/controlador_interrupcao_pkg.sv
// Shared definitions for the interrupt controller.
// - estado_t : interrupt entry/return sequencer states (3-bit)
// - ID_WIDTH : width of the serviced interrupt ID (index + 1, 0 = none)
package controlador_interrupcao_pkg;

    localparam int unsigned ID_WIDTH = 4;

    typedef enum logic [2:0] {
        OCIOSO     = 3'd0,
        SALVA      = 3'd1,
        DESVIA     = 3'd2,
        EM_SERVICO = 3'd3,
        RETORNA    = 3'd4
    } estado_t;

endpackage

// File: rtl/controlador_interrupcao_detector_borda_irq.sv
// Per-line rising-edge detector feeding a pending-request register.
// Ports:
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   irq            : request lines, synchronous to clock
//   limpa          : bits to clear this cycle (serviced request)
//   pendentes      : pending request bits
module detector_borda_irq #(
    parameter int unsigned NUM_IRQ = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] limpa,
    output logic [NUM_IRQ-1:0] pendentes
);

    logic [NUM_IRQ-1:0] irq_ant;
    logic [NUM_IRQ-1:0] borda;

    assign borda = irq & ~irq_ant;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            irq_ant   <= '0;
            pendentes <= '0;
        end else begin
            irq_ant   <= irq;
            // Set after clear: an edge arriving while its bit is being
            // serviced must not be lost.
            pendentes <= (pendentes & ~limpa) | borda;
        end
    end

endmodule

// File: rtl/controlador_interrupcao.sv
// Interrupt entry/return sequencer.
// Latches irq edges, picks the lowest-index pending request at an
// instruction boundary, saves the return PC and drives the PC-source
// pulses and PC/interrupt mux selects. No nesting.
// Ports:
//   clock, reset_n                 : clock, async active-low reset
//   irq                            : request lines (rising-edge sensitive)
//   habilita_interrup              : global interrupt enable
//   fim_instrucao                  : instruction boundary pulse
//   valor_pc                       : address of next instruction
//   reti                           : return-from-interrupt pulse
//   op_save_pc/op_get_pc/op_get_irq: software read requests
//   pc_interrup, qual_interrupcao  : saved return PC, serviced ID
//   desvia_interrup, endereco_vetor: jump-to-handler pulse and address
//   retorna_pc                     : return-to-saved-PC pulse
//   save_pc/get_pc_interrup/get_interruption : mux selects (one-hot or 0)
//   pendentes, em_servico          : pending bits, in-service flag
module controlador_interrupcao
    import controlador_interrupcao_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH     = 32,
    parameter int unsigned           ADDR_WIDTH     = 13,
    parameter int unsigned           NUM_IRQ        = 4,
    parameter logic [ADDR_WIDTH-1:0] VETOR_INTERRUP = 13'h0010
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [NUM_IRQ-1:0]    irq,
    input  logic                  habilita_interrup,
    input  logic                  fim_instrucao,
    input  logic [ADDR_WIDTH-1:0] valor_pc,
    input  logic                  reti,
    input  logic                  op_save_pc,
    input  logic                  op_get_pc,
    input  logic                  op_get_irq,
    output logic [ADDR_WIDTH-1:0] pc_interrup,
    output logic [DATA_WIDTH-1:0] qual_interrupcao,
    output logic                  desvia_interrup,
    output logic [ADDR_WIDTH-1:0] endereco_vetor,
    output logic                  retorna_pc,
    output logic                  save_pc,
    output logic                  get_pc_interrup,
    output logic                  get_interruption,
    output logic [NUM_IRQ-1:0]    pendentes,
    output logic                  em_servico
);

    estado_t             estado;
    logic [NUM_IRQ-1:0]  limpa;
    logic [NUM_IRQ-1:0]  vencedor_mask;
    logic [ID_WIDTH-1:0] vencedor_id;

    detector_borda_irq #(
        .NUM_IRQ (NUM_IRQ)
    ) u_detector (
        .clock     (clock),
        .reset_n   (reset_n),
        .irq       (irq),
        .limpa     (limpa),
        .pendentes (pendentes)
    );

    // Fixed priority: scan from the top so the lowest index is written last.
    always_comb begin
        vencedor_id   = '0;
        vencedor_mask = '0;
        for (int unsigned i = NUM_IRQ; i > 0; i--) begin
            if (pendentes[i-1]) begin
                vencedor_id            = ID_WIDTH'(i);
                vencedor_mask          = '0;
                vencedor_mask[i-1]     = 1'b1;
            end
        end
    end

    assign limpa = (estado == SALVA) ? vencedor_mask : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado           <= OCIOSO;
            pc_interrup      <= '0;
            qual_interrupcao <= '0;
            desvia_interrup  <= 1'b0;
            retorna_pc       <= 1'b0;
            em_servico       <= 1'b0;
        end else begin
            desvia_interrup <= 1'b0;
            retorna_pc      <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (habilita_interrup && fim_instrucao && (|pendentes)) begin
                        estado     <= SALVA;
                        em_servico <= 1'b1;
                    end
                end
                SALVA: begin
                    pc_interrup      <= valor_pc;
                    qual_interrupcao <= DATA_WIDTH'(vencedor_id);
                    desvia_interrup  <= 1'b1;
                    estado           <= DESVIA;
                end
                DESVIA: begin
                    estado <= EM_SERVICO;
                end
                EM_SERVICO: begin
                    if (reti) begin
                        retorna_pc <= 1'b1;
                        estado     <= RETORNA;
                    end
                end
                RETORNA: begin
                    qual_interrupcao <= '0;
                    em_servico       <= 1'b0;
                    estado           <= OCIOSO;
                end
                default: estado <= OCIOSO;
            endcase
        end
    end

    assign endereco_vetor = VETOR_INTERRUP;

    // Selects are held low while reset is asserted.
    assign save_pc          = reset_n & op_save_pc;
    assign get_pc_interrup  = reset_n & ~op_save_pc & op_get_pc;
    assign get_interruption = reset_n & ~op_save_pc & ~op_get_pc & op_get_irq;

endmodule

// File: tb/tb_controlador_interrupcao.sv
module tb_controlador_interrupcao;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [3:0]  irq;
    logic        habilita_interrup;
    logic        fim_instrucao;
    logic [12:0] valor_pc;
    logic        reti;
    logic        op_save_pc, op_get_pc, op_get_irq;
    logic [12:0] pc_interrup;
    logic [31:0] qual_interrupcao;
    logic        desvia_interrup;
    logic [12:0] endereco_vetor;
    logic        retorna_pc;
    logic        save_pc, get_pc_interrup, get_interruption;
    logic [3:0]  pendentes;
    logic        em_servico;

    controlador_interrupcao #(
        .DATA_WIDTH     (32),
        .ADDR_WIDTH     (13),
        .NUM_IRQ        (4),
        .VETOR_INTERRUP (13'h0010)
    ) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .irq               (irq),
        .habilita_interrup (habilita_interrup),
        .fim_instrucao     (fim_instrucao),
        .valor_pc          (valor_pc),
        .reti              (reti),
        .op_save_pc        (op_save_pc),
        .op_get_pc         (op_get_pc),
        .op_get_irq        (op_get_irq),
        .pc_interrup       (pc_interrup),
        .qual_interrupcao  (qual_interrupcao),
        .desvia_interrup   (desvia_interrup),
        .endereco_vetor    (endereco_vetor),
        .retorna_pc        (retorna_pc),
        .save_pc           (save_pc),
        .get_pc_interrup   (get_pc_interrup),
        .get_interruption  (get_interruption),
        .pendentes         (pendentes),
        .em_servico        (em_servico)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int erros  = 0;

    // Reference model: timestamps of entry / reti instead of a state machine.
    int          cyc;
    int          t_entry;
    int          t_reti;
    bit          m_busy;
    logic [3:0]  m_pend;
    logic [3:0]  m_prev;
    logic [12:0] m_pc;
    int          m_id;

    task automatic verifica(input string tag, input logic [63:0] obs, input logic [63:0] esp);
        checks++;
        if (obs !== esp) begin
            erros++;
            $display("FAIL %s: observado=%0h esperado=%0h (ciclo %0d)", tag, obs, esp, cyc);
        end
    endtask

    task automatic modelo_reset();
        cyc     = 0;
        t_entry = -10;
        t_reti  = -1;
        m_busy  = 1'b0;
        m_pend  = '0;
        m_prev  = '0;
        m_pc    = '0;
        m_id    = 0;
    endtask

    // One clock cycle: drive inputs, check outputs against the model,
    // then advance the model with the inputs the DUT sampled.
    task automatic passo(input logic [3:0] i_irq, input logic i_en, input logic i_fim,
                         input logic i_reti, input logic [12:0] i_pc, input logic [2:0] i_op);
        logic [3:0] bordas;
        logic [3:0] menor;
        int         w;
        @(negedge clock);
        irq = i_irq; habilita_interrup = i_en; fim_instrucao = i_fim;
        reti = i_reti; valor_pc = i_pc;
        {op_save_pc, op_get_pc, op_get_irq} = i_op;
        #1;
        verifica("desvia", desvia_interrup, m_busy && (cyc == t_entry + 2));
        verifica("retorna", retorna_pc, m_busy && (t_reti >= 0) && (cyc == t_reti + 1));
        verifica("em_servico", em_servico, m_busy);
        verifica("pendentes", pendentes, m_pend);
        verifica("pc_interrup", pc_interrup, m_pc);
        verifica("qual", qual_interrupcao, m_id);
        verifica("vetor", endereco_vetor, 13'h0010);
        verifica("save_pc", save_pc, i_op[2]);
        verifica("get_pc", get_pc_interrup, i_op[1] & ~i_op[2]);
        verifica("get_irq", get_interruption, i_op[0] & ~i_op[1] & ~i_op[2]);
        @(posedge clock);
        bordas = i_irq & ~m_prev;
        if (!m_busy) begin
            if (i_en && i_fim && (m_pend != 0)) begin
                m_busy  = 1'b1;
                t_entry = cyc;
                t_reti  = -1;
            end
        end else if (cyc == t_entry + 1) begin
            menor  = m_pend & (~m_pend + 4'd1);
            w      = $clog2(menor);
            m_pc   = i_pc;
            m_id   = w + 1;
            m_pend = m_pend & ~menor;
        end else if (t_reti >= 0) begin
            if (cyc == t_reti + 1) begin
                m_busy = 1'b0;
                m_id   = 0;
            end
        end else if (cyc >= t_entry + 3 && i_reti) begin
            t_reti = cyc;
        end
        m_pend = m_pend | bordas;
        m_prev = i_irq;
        cyc++;
        #1;
    endtask

    initial begin
        int ok;
        logic [3:0]  r_irq;
        reset_n = 1'b0;
        irq = '0; habilita_interrup = 1'b0; fim_instrucao = 1'b0;
        valor_pc = '0; reti = 1'b0;
        op_save_pc = 1'b0; op_get_pc = 1'b0; op_get_irq = 1'b0;
        modelo_reset();
        #12;
        verifica("reset_em_servico", em_servico, 1'b0);
        verifica("reset_pendentes", pendentes, 4'b0000);
        @(negedge clock);
        reset_n = 1'b1;

        // 1: single request, entry latency, saved PC and ID
        passo(4'b0100, 1, 0, 0, 13'h0000, 3'b000);
        passo(4'b0100, 1, 1, 0, 13'h0123, 3'b000);
        passo(4'b0100, 1, 0, 0, 13'h0123, 3'b000);
        verifica("t1_pc", pc_interrup, 13'h0123);
        verifica("t1_qual", qual_interrupcao, 32'd3);
        verifica("t1_pend", pendentes, 4'b0000);
        passo(4'b0100, 1, 0, 0, 13'h0000, 3'b000);
        passo(4'b0100, 1, 0, 1, 13'h0000, 3'b000);
        passo(4'b0000, 1, 0, 0, 13'h0000, 3'b000);

        // 2: simultaneous edges on 1 and 3, lowest wins, 3 stays pending
        passo(4'b1010, 1, 0, 0, 13'h0000, 3'b000);
        passo(4'b1010, 1, 1, 0, 13'h0200, 3'b000);
        passo(4'b1010, 1, 0, 0, 13'h0200, 3'b000);
        verifica("t2_qual", qual_interrupcao, 32'd2);
        verifica("t2_pend", pendentes, 4'b1000);
        passo(4'b1010, 1, 0, 0, 13'h0000, 3'b000);
        passo(4'b1010, 1, 1, 0, 13'h0000, 3'b000);
        passo(4'b1010, 1, 0, 1, 13'h0000, 3'b000);
        passo(4'b1010, 1, 0, 0, 13'h0000, 3'b000);
        passo(4'b1010, 1, 1, 0, 13'h0300, 3'b000);
        passo(4'b1010, 1, 0, 0, 13'h0300, 3'b000);
        verifica("t2_qual2", qual_interrupcao, 32'd4);

        // 3: edge during service is latched but not taken until after return
        passo(4'b1010, 1, 0, 0, 13'h0000, 3'b000);
        passo(4'b1011, 1, 1, 0, 13'h0000, 3'b000);
        passo(4'b1011, 1, 1, 0, 13'h0000, 3'b000);
        verifica("t3_pend", pendentes, 4'b0001);
        passo(4'b1011, 1, 0, 1, 13'h0000, 3'b000);
        passo(4'b1011, 1, 0, 0, 13'h0000, 3'b000);
        passo(4'b1011, 1, 1, 0, 13'h0400, 3'b000);
        passo(4'b1011, 1, 0, 0, 13'h0400, 3'b000);
        verifica("t3_qual", qual_interrupcao, 32'd1);
        passo(4'b0000, 1, 0, 0, 13'h0000, 3'b000);
        passo(4'b0000, 1, 0, 1, 13'h0000, 3'b000);
        passo(4'b0000, 1, 0, 0, 13'h0000, 3'b000);

        // 5: new edge in the SALVA cycle survives the clear; reti while idle
        passo(4'b0100, 1, 0, 0, 13'h0000, 3'b000);
        passo(4'b0000, 1, 1, 0, 13'h0500, 3'b000);
        passo(4'b0100, 1, 0, 0, 13'h0500, 3'b000);
        verifica("t5_pend", pendentes, 4'b0100);
        verifica("t5_qual", qual_interrupcao, 32'd3);
        passo(4'b0100, 1, 0, 0, 13'h0000, 3'b000);
        passo(4'b0100, 1, 0, 1, 13'h0000, 3'b000);
        passo(4'b0100, 1, 0, 0, 13'h0000, 3'b000);
        passo(4'b0100, 1, 0, 1, 13'h0000, 3'b000);
        passo(4'b0100, 1, 0, 0, 13'h0000, 3'b000);
        verifica("t5_reti_ocioso", retorna_pc, 1'b0);

        // 6a: select priority
        passo(4'b0100, 0, 0, 0, 13'h0000, 3'b101);
        verifica("t6_save", save_pc, 1'b1);
        verifica("t6_get_irq", get_interruption, 1'b0);

        // Random phase: enable mostly low first (accumulate), then mostly high
        r_irq = 4'b0100;
        for (int k = 0; k < 400; k++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 7) == 0) r_irq[b] = ~r_irq[b];
            passo(r_irq,
                  (k < 100) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 7) != 0),
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 5) == 0,
                  13'($urandom),
                  3'($urandom));
        end

        // 6b: async reset in the middle of a service
        ok = 0;
        for (int k = 0; k < 200 && ok == 0; k++) begin
            r_irq = 4'($urandom);
            passo(r_irq, 1, 1, 0, 13'($urandom), 3'b000);
            if (m_busy && cyc >= t_entry + 3) ok = 1;
        end
        verifica("espera_servico", ok, 1);
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        op_save_pc = 1'b1;
        #1;
        verifica("rst_em_servico", em_servico, 1'b0);
        verifica("rst_pc", pc_interrup, 13'h0000);
        verifica("rst_qual", qual_interrupcao, 32'd0);
        verifica("rst_pend", pendentes, 4'b0000);
        verifica("rst_save_pc", save_pc, 1'b0);
        verifica("rst_vetor", endereco_vetor, 13'h0010);
        irq = '0;
        modelo_reset();
        @(negedge clock);
        reset_n = 1'b1;
        r_irq = '0;
        for (int k = 0; k < 60; k++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 5) == 0) r_irq[b] = ~r_irq[b];
            passo(r_irq, 1, $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0,
                  13'($urandom), 3'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, erros);
        $finish;
    end

endmodule
